// File: rtl/lsu_unit_if.sv
// Execute-side request/response and data-memory bus of the rv32i load/store unit.
// The master modport is the LSU's view; slave is the view of the environment around it.
interface lsu_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        err_o;
  logic [1:0]  err_cause_o;

  modport master (
    input  req_valid_i, req_we_i, funct3_i, addr_i, wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output rsp_valid_o, rsp_data_o, err_o, err_cause_o
  );

  modport slave (
    output req_valid_i, req_we_i, funct3_i, addr_i, wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  rsp_valid_o, rsp_data_o, err_o, err_cause_o
  );
endinterface

// File: rtl/lsu_unit.sv
// rv32i load/store unit: one data-memory transaction per accepted op, with
// alignment/funct3 checks, byte-lane steering, load extension and a busy timeout.
module lsu_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  lsu_unit_if.master bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN   = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  state_t        r_state;
  logic          r_ready;
  logic          r_we;
  logic [2:0]    r_funct3;
  logic [1:0]    r_off;
  logic [CW-1:0] r_cnt;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [31:0]   r_mem_addr;
  logic [3:0]    r_mem_be;
  logic [31:0]   r_mem_wdata;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_data;
  logic          r_err;
  logic [1:0]    r_err_cause;

  logic          w_accept;
  logic          w_illegal;
  logic          w_misalign;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_shifted;
  logic [31:0]   w_load_data;
  logic [CW-1:0] w_cnt_next;
  logic          w_timeout;

  assign w_accept   = bus.req_valid_i && r_ready;
  assign w_illegal  = bus.req_we_i
                    ? (bus.funct3_i[2] || bus.funct3_i[1:0] == 2'b11)
                    : (bus.funct3_i[1:0] == 2'b11 || bus.funct3_i == 3'b110);
  assign w_misalign = (bus.funct3_i[1:0] == 2'b01 && bus.addr_i[0])
                   || (bus.funct3_i[1:0] == 2'b10 && bus.addr_i[1:0] != 2'b00);
  assign w_cnt_next = r_cnt + 1'b1;
  // Fires on the last permitted busy cycle; only a completing event in that cycle avoids the abort.
  assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == CW'(TIMEOUT));

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.wdata_i;
    case (bus.funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << bus.addr_i[1:0];
        w_wdata = {4{bus.wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << bus.addr_i[1:0];
        w_wdata = {2{bus.wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_shifted = bus.mem_rdata_i >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'b0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'b0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0;
      r_err       <= 1'b0;
      r_err_cause <= CAUSE_NONE;
    end else begin
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready  <= 1'b0;
            r_we     <= bus.req_we_i;
            r_funct3 <= bus.funct3_i;
            r_off    <= bus.addr_i[1:0];
            r_cnt    <= '0;
            if (w_illegal || w_misalign) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= 32'h0;
              r_err       <= 1'b1;
              r_err_cause <= w_illegal ? CAUSE_ILLEGAL : CAUSE_ALIGN;
            end else begin
              r_state     <= S_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.req_we_i;
              r_mem_addr  <= {bus.addr_i[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end
        S_REQ: begin
          r_cnt <= w_cnt_next;
          if (bus.mem_gnt_i && r_we) begin
            r_state     <= S_RESP;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 32'h0;
            r_err_cause <= CAUSE_NONE;
          end else if (w_timeout) begin
            r_state     <= S_RESP;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 32'h0;
            r_err       <= 1'b1;
            r_err_cause <= CAUSE_TIMEOUT;
          end else if (bus.mem_gnt_i) begin
            r_state   <= S_WAIT;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_next;
          if (bus.mem_rvalid_i) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_load_data;
            r_err_cause <= CAUSE_NONE;
          end else if (w_timeout) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 32'h0;
            r_err       <= 1'b1;
            r_err_cause <= CAUSE_TIMEOUT;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = r_ready;
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_be_o    = r_mem_be;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_data_o  = r_rsp_data;
  assign bus.err_o       = r_err;
  assign bus.err_cause_o = r_err_cause;

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed cases plus randomized ops with random
// grant/rvalid latencies, compared against a byte-level reference model.
module tb_lsu_unit;

  localparam int TO = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_pass   = 0;

  lsu_unit_if bus();

  lsu_unit #(.TIMEOUT(TO)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  cause;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] data;
  } exp_t;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Access size from funct3, lanes replicated by byte index modulo size, load value
  // cut out of the word arithmetically and extended by testing its top bit.
  function automatic exp_t model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                 input bit [31:0] wdata, input bit [31:0] rdata);
    exp_t e;
    int size, off;
    bit sgn, legal;
    longint unsigned mask, v;
    size = 4; sgn = 0; legal = 1;
    case (f3)
      3'd0:    begin size = 1; sgn = 1; end
      3'd1:    begin size = 2; sgn = 1; end
      3'd2:    size = 4;
      3'd4:    begin size = 1; legal = !we; end
      3'd5:    begin size = 2; legal = !we; end
      default: legal = 0;
    endcase
    off = int'(addr[1:0]);
    e.cause = !legal ? 2'd2 : ((off % size) != 0) ? 2'd1 : 2'd0;
    e.be = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = wdata[8*(i % size) +: 8];
    mask = (64'd1 << (8*size)) - 1;
    v = (64'(rdata) >> (8*off)) & mask;
    if (sgn && v[8*size-1]) v = v | ~mask;
    e.data = (we || e.cause != 0) ? 32'h0 : v[31:0];
    return e;
  endfunction

  function automatic bit noise();
    return $urandom_range(0, 3) == 0;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ctl"}, {bus.req_ready_o, bus.mem_req_o, bus.mem_we_o, bus.rsp_valid_o, bus.err_o},
          5'b10000);
    check({tag, " mem"}, {bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o}, 68'h0);
    check({tag, " rsp"}, {bus.rsp_data_o, bus.err_cause_o}, 34'h0);
  endtask

  // Unit is idle: random bus noise must not produce activity.
  task automatic idle(input int n, input bit force_rv);
    for (int k = 0; k < n; k++) begin
      bus.mem_gnt_i    = noise();
      bus.mem_rvalid_i = force_rv ? 1'b1 : noise();
      bus.mem_rdata_i  = $urandom();
      next_cycle();
      check($sformatf("idle%0d", k), {bus.req_ready_o, bus.rsp_valid_o, bus.mem_req_o}, 3'b100);
    end
  endtask

  task automatic reset_pulse(input int id);
    #1 rst_i = 1'b1;
    #1 check_reset($sformatf("op%0d rst", id));
    next_cycle();
    check($sformatf("op%0d rst hold", id), {bus.mem_req_o, bus.rsp_valid_o}, 2'b00);
    #2 rst_i = 1'b0;
    idle(3, 1'b0);
  endtask

  // Cycle 0 is the current cycle (unit idle). g = cycles from cycle 1 to grant,
  // r = cycles from the WAIT entry to rvalid. abort_at > 0 pulses reset in that cycle.
  task automatic run_op(input int id, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wdata, input bit [31:0] rdata, input int g, input int r,
                        input int abort_at);
    exp_t e;
    int busy, rc, req_last;
    bit is_err;
    e = model(we, f3, addr, wdata, rdata);
    is_err = (e.cause != 0);
    busy = we ? g + 1 : g + r + 2;
    rc = is_err ? 1 : 1 + ((busy > TO) ? TO : busy);
    req_last = is_err ? 0 : 1 + ((g < TO - 1) ? g : TO - 1);
    if (!is_err && busy > TO) begin
      e.cause = 2'd3;
      e.data  = 32'h0;
    end
    check($sformatf("op%0d ready0", id), bus.req_ready_o, 1'b1);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.funct3_i    = f3;
    bus.addr_i      = addr;
    bus.wdata_i     = wdata;
    for (int c = 1; c <= rc + 1; c++) begin
      next_cycle();
      bus.req_valid_i = 1'b0;
      if (is_err) begin
        bus.mem_gnt_i    = noise();
        bus.mem_rvalid_i = noise();
      end else begin
        bus.mem_gnt_i    = (c == 1 + g) ? 1'b1 : (c > 1 + g) ? noise() : 1'b0;
        bus.mem_rvalid_i = (!we && c == 2 + g + r) ? 1'b1 : (c <= 1 + g) ? noise() : 1'b0;
      end
      bus.mem_rdata_i = (c == 2 + g + r) ? rdata : $urandom();
      if (c == rc + 1) begin
        check($sformatf("op%0d end ctl", id), {bus.req_ready_o, bus.rsp_valid_o, bus.mem_req_o},
              3'b100);
        check($sformatf("op%0d hold", id), {bus.rsp_data_o, bus.err_cause_o}, {e.data, e.cause});
      end else begin
        check($sformatf("op%0d c%0d req", id, c), bus.mem_req_o, c <= req_last);
        if (c <= req_last)
          check($sformatf("op%0d c%0d bus", id, c),
                {bus.mem_we_o, bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o},
                {we, addr[31:2], 2'b00, e.be, e.wd});
        check($sformatf("op%0d c%0d vld/rdy", id, c), {bus.rsp_valid_o, bus.req_ready_o},
              {c == rc, 1'b0});
        if (c == rc)
          check($sformatf("op%0d rsp", id), {bus.err_o, bus.err_cause_o, bus.rsp_data_o},
                {e.cause != 0, e.cause, e.data});
      end
      if (c == abort_at) begin
        reset_pulse(id);
        return;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i            = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.funct3_i     = 3'b000;
    bus.addr_i       = 32'h0;
    bus.wdata_i      = 32'h0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;
    #2 rst_i = 1'b1;
    #1 check_reset("por");
    next_cycle();
    next_cycle();
    #2 rst_i = 1'b0;
    idle(2, 1'b0);

    run_op(1, 1'b0, 3'b000, 32'h0000_1003, $urandom(), 32'h8011_2233, 0, 0, 0);  // LB
    run_op(2, 1'b0, 3'b101, 32'h0000_2002, $urandom(), 32'hBEEF_1234, 0, 1, 0);  // LHU
    run_op(3, 1'b0, 3'b001, 32'h0000_2002, $urandom(), 32'hBEEF_1234, 1, 0, 0);  // LH
    run_op(4, 1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, $urandom(), 2, 0, 0);  // SB
    run_op(5, 1'b1, 3'b010, 32'h0000_5000, 32'h1234_5678, $urandom(), 0, 0, 0);  // SW back-to-back
    run_op(6, 1'b1, 3'b001, 32'h0000_5006, 32'hCAFE_F00D, $urandom(), 0, 0, 0);  // SH
    run_op(7, 1'b0, 3'b010, 32'h0000_4002, $urandom(), $urandom(), 0, 0, 0);     // LW misaligned
    run_op(8, 1'b0, 3'b011, 32'h0000_4000, $urandom(), $urandom(), 0, 0, 0);     // illegal load
    run_op(9, 1'b1, 3'b100, 32'h0000_4000, $urandom(), $urandom(), 0, 0, 0);     // illegal store
    run_op(10, 1'b0, 3'b010, 32'h0000_6000, $urandom(), $urandom(), 20, 0, 0);   // never granted
    idle(2, 1'b1);                                                               // late rvalid
    run_op(11, 1'b0, 3'b010, 32'h0000_7000, $urandom(), $urandom(), 3, 0, 0);    // grant on last cycle
    run_op(12, 1'b0, 3'b100, 32'h0000_7001, $urandom(), 32'h00C3_0000, 2, 0, 0); // rvalid on last cycle
    run_op(13, 1'b0, 3'b010, 32'h0000_0100, $urandom(), $urandom(), 0, 5, 2);    // reset in WAIT
    run_op(14, 1'b1, 3'b010, 32'h0000_0200, $urandom(), $urandom(), 9, 0, 2);    // reset in REQ
    run_op(15, 1'b0, 3'b010, 32'h0000_0000, $urandom(), 32'h1357_9BDF, 0, 0, 0); // LW after reset

    for (int i = 0; i < 160; i++) begin
      bit [31:0] a;
      a = $urandom();
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_op(100 + i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(),
             $urandom(), $urandom_range(0, 5), $urandom_range(0, 3), 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
